// File: rtl/pad_ctrl.sv
// GPIO pad controller: registered pad-cell drive, synchronized and debounced input, edge interrupt.
// Pad outputs lag their controls by one cycle; the input level lags the pad by thresh+3 edges.
module pad_ctrl #(
   parameter int DEB_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             out_val_i,
   input  logic             out_en_i,
   input  logic             in_en_i,
   input  logic             od_i,
   input  logic [1:0]       pull_i,
   input  logic [1:0]       irq_mode_i,
   input  logic             irq_clr_i,
   input  logic [DEB_W-1:0] deb_thresh_i,
   output logic             pad_dout_o,
   output logic             pad_eno_o,
   output logic             pad_eni_o,
   output logic             pad_od_o,
   output logic             pad_pu1_o,
   output logic             pad_pu2_o,
   input  logic             pad_din_i,
   output logic             in_val_o,
   output logic             irq_o
);

   logic             s1_q, s2_q;
   logic [DEB_W-1:0] cnt_q, cnt_d;
   logic             in_val_q, in_val_d;
   logic             pend_q, pend_d;
   logic             rise, fall;

   always_comb begin
      cnt_d    = '0;
      in_val_d = in_val_q;
      rise     = 1'b0;
      fall     = 1'b0;
      // A matching sample, or a disabled input, restarts the count from zero.
      if (in_en_i && (s2_q != in_val_q)) begin
         if (cnt_q == deb_thresh_i) begin
            in_val_d = s2_q;
            rise     = s2_q;
            fall     = ~s2_q;
         end else begin
            cnt_d = cnt_q + DEB_W'(1);
         end
      end
      pend_d = (rise & irq_mode_i[0]) | (fall & irq_mode_i[1]) | (pend_q & ~irq_clr_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pad_dout_o <= 1'b0;
         pad_eno_o  <= 1'b0;
         pad_eni_o  <= 1'b0;
         pad_od_o   <= 1'b0;
         pad_pu1_o  <= 1'b0;
         pad_pu2_o  <= 1'b0;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         cnt_q      <= '0;
         in_val_q   <= 1'b0;
         pend_q     <= 1'b0;
      end else begin
         // Open-drain only ever pulls low; a 1 releases the pad.
         pad_dout_o <= od_i ? 1'b0 : out_val_i;
         pad_eno_o  <= out_en_i & ~(od_i & out_val_i);
         pad_eni_o  <= in_en_i;
         pad_od_o   <= od_i;
         pad_pu1_o  <= pull_i[0];
         pad_pu2_o  <= pull_i[1];
         s1_q       <= pad_din_i;
         s2_q       <= s1_q;
         cnt_q      <= cnt_d;
         in_val_q   <= in_val_d;
         pend_q     <= pend_d;
      end
   end

   assign in_val_o = in_val_q;
   assign irq_o    = pend_q;

endmodule

// File: tb/tb_pad_ctrl.sv
// Directed bench for pad_ctrl: drive path, debounce timing, interrupts and reset.
module tb_pad_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       out_val_i = 1'b0, out_en_i = 1'b0, in_en_i = 1'b0, od_i = 1'b0;
   logic [1:0] pull_i = 2'b00, irq_mode_i = 2'b00;
   logic       irq_clr_i = 1'b0;
   logic [7:0] deb_thresh_i = 8'd3;
   logic       pad_din_i = 1'b0;
   logic       pad_dout_o, pad_eno_o, pad_eni_o, pad_od_o, pad_pu1_o, pad_pu2_o;
   logic       in_val_o, irq_o;
   int         checks = 0;
   int         errors = 0;

   pad_ctrl #(.DEB_W(8)) dut (
      .clk(clk), .rst(rst),
      .out_val_i(out_val_i), .out_en_i(out_en_i), .in_en_i(in_en_i), .od_i(od_i),
      .pull_i(pull_i), .irq_mode_i(irq_mode_i), .irq_clr_i(irq_clr_i),
      .deb_thresh_i(deb_thresh_i),
      .pad_dout_o(pad_dout_o), .pad_eno_o(pad_eno_o), .pad_eni_o(pad_eni_o),
      .pad_od_o(pad_od_o), .pad_pu1_o(pad_pu1_o), .pad_pu2_o(pad_pu2_o),
      .pad_din_i(pad_din_i), .in_val_o(in_val_o), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({pad_dout_o, pad_eno_o, pad_eni_o, pad_od_o, pad_pu1_o, pad_pu2_o, in_val_o, irq_o} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 00000000",
                  {pad_dout_o, pad_eno_o, pad_eni_o, pad_od_o, pad_pu1_o, pad_pu2_o, in_val_o, irq_o});
      end
      rst = 1'b0;
   endtask

   task automatic test_debounce();
      in_en_i = 1'b1;
      pad_din_i = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         checks++;
         if (in_val_o !== (i == 6)) begin
            errors++;
            $display("FAIL debounce_rise edge %0d: got %b expected %b", i, in_val_o, (i == 6));
         end
      end
      pad_din_i = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         checks++;
         if (in_val_o !== (i < 6)) begin
            errors++;
            $display("FAIL debounce_fall edge %0d: got %b expected %b", i, in_val_o, (i < 6));
         end
      end
   endtask

   task automatic test_glitch();
      pad_din_i = 1'b1;
      tick();
      tick();
      tick();
      pad_din_i = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         checks++;
         if (in_val_o !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject edge %0d: got %b expected 0", i, in_val_o);
         end
      end
      // The count must have restarted: a real change needs the full six edges.
      pad_din_i = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         checks++;
         if (in_val_o !== (i == 6)) begin
            errors++;
            $display("FAIL glitch_recount edge %0d: got %b expected %b", i, in_val_o, (i == 6));
         end
      end
   endtask

   task automatic test_irq();
      irq_mode_i = 2'b01;
      pad_din_i = 1'b0;
      repeat (6) tick();
      checks++;
      if ({in_val_o, irq_o} !== 2'b00) begin
         errors++;
         $display("FAIL irq_no_fall: got %b expected 00", {in_val_o, irq_o});
      end
      pad_din_i = 1'b1;
      repeat (5) tick();
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL irq_early: got %b expected 0", irq_o);
      end
      tick();
      checks++;
      if ({in_val_o, irq_o} !== 2'b11) begin
         errors++;
         $display("FAIL irq_rise: got %b expected 11", {in_val_o, irq_o});
      end
      repeat (3) tick();
      checks++;
      if (irq_o !== 1'b1) begin
         errors++;
         $display("FAIL irq_hold: got %b expected 1", irq_o);
      end
      pad_din_i = 1'b0;
      repeat (6) tick();
      checks++;
      if ({in_val_o, irq_o} !== 2'b01) begin
         errors++;
         $display("FAIL irq_fall_keep: got %b expected 01", {in_val_o, irq_o});
      end
      irq_mode_i = 2'b00;
      tick();
      checks++;
      if (irq_o !== 1'b1) begin
         errors++;
         $display("FAIL irq_mode_change: got %b expected 1", irq_o);
      end
      irq_clr_i = 1'b1;
      tick();
      irq_clr_i = 1'b0;
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL irq_clear: got %b expected 0", irq_o);
      end
      tick();
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL irq_stay_clear: got %b expected 0", irq_o);
      end
      irq_mode_i = 2'b01;
   endtask

   task automatic test_set_clear();
      irq_mode_i = 2'b11;
      pad_din_i = 1'b1;
      repeat (5) tick();
      irq_clr_i = 1'b1;
      tick();
      irq_clr_i = 1'b0;
      checks++;
      if ({in_val_o, irq_o} !== 2'b11) begin
         errors++;
         $display("FAIL set_wins: got %b expected 11", {in_val_o, irq_o});
      end
      tick();
      checks++;
      if (irq_o !== 1'b1) begin
         errors++;
         $display("FAIL set_wins_hold: got %b expected 1", irq_o);
      end
      irq_clr_i = 1'b1;
      tick();
      irq_clr_i = 1'b0;
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL set_clear_after: got %b expected 0", irq_o);
      end
   endtask

   task automatic test_disable();
      in_en_i = 1'b0;
      pad_din_i = 1'b0;
      tick();
      checks++;
      if (pad_eni_o !== 1'b0) begin
         errors++;
         $display("FAIL disable_eni: got %b expected 0", pad_eni_o);
      end
      repeat (9) tick();
      checks++;
      if ({in_val_o, irq_o} !== 2'b10) begin
         errors++;
         $display("FAIL disable_frozen: got %b expected 10", {in_val_o, irq_o});
      end
      in_en_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if ({in_val_o, irq_o} !== ((i == 4) ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL disable_resume edge %0d: got %b expected %b", i, {in_val_o, irq_o},
                     ((i == 4) ? 2'b01 : 2'b10));
         end
      end
   endtask

   task automatic test_thresh0();
      deb_thresh_i = 8'd0;
      pad_din_i = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if (in_val_o !== (i == 3)) begin
            errors++;
            $display("FAIL thresh0 edge %0d: got %b expected %b", i, in_val_o, (i == 3));
         end
      end
      deb_thresh_i = 8'd3;
   endtask

   task automatic test_open_drain();
      od_i = 1'b1;
      out_en_i = 1'b1;
      out_val_i = 1'b0;
      pull_i = 2'b10;
      tick();
      checks++;
      if ({pad_dout_o, pad_eno_o, pad_od_o, pad_pu1_o, pad_pu2_o} !== 5'b01101) begin
         errors++;
         $display("FAIL od_low: got %b expected 01101",
                  {pad_dout_o, pad_eno_o, pad_od_o, pad_pu1_o, pad_pu2_o});
      end
      out_val_i = 1'b1;
      #1;
      checks++;
      if (pad_eno_o !== 1'b1) begin
         errors++;
         $display("FAIL od_latency: got %b expected 1", pad_eno_o);
      end
      tick();
      checks++;
      if ({pad_dout_o, pad_eno_o} !== 2'b00) begin
         errors++;
         $display("FAIL od_release: got %b expected 00", {pad_dout_o, pad_eno_o});
      end
      od_i = 1'b0;
      tick();
      checks++;
      if ({pad_dout_o, pad_eno_o, pad_od_o} !== 3'b110) begin
         errors++;
         $display("FAIL pp_drive: got %b expected 110", {pad_dout_o, pad_eno_o, pad_od_o});
      end
      out_en_i = 1'b0;
      tick();
      checks++;
      if ({pad_dout_o, pad_eno_o} !== 2'b10) begin
         errors++;
         $display("FAIL pp_disable: got %b expected 10", {pad_dout_o, pad_eno_o});
      end
   endtask

   task automatic test_reset_mid_op();
      irq_clr_i = 1'b1;
      tick();
      irq_clr_i = 1'b0;
      irq_mode_i = 2'b01;
      pad_din_i = 1'b0;
      repeat (6) tick();
      pad_din_i = 1'b1;
      repeat (6) tick();
      od_i = 1'b0;
      out_val_i = 1'b1;
      out_en_i = 1'b1;
      pull_i = 2'b11;
      pad_din_i = 1'b0;
      repeat (4) tick();
      checks++;
      if ({pad_dout_o, pad_eno_o, pad_pu1_o, pad_pu2_o, in_val_o, irq_o} !== 6'b111111) begin
         errors++;
         $display("FAIL pre_reset: got %b expected 111111",
                  {pad_dout_o, pad_eno_o, pad_pu1_o, pad_pu2_o, in_val_o, irq_o});
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({pad_dout_o, pad_eno_o, pad_eni_o, pad_od_o, pad_pu1_o, pad_pu2_o, in_val_o, irq_o} !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid_op: got %b expected 00000000",
                  {pad_dout_o, pad_eno_o, pad_eni_o, pad_od_o, pad_pu1_o, pad_pu2_o, in_val_o, irq_o});
      end
      rst = 1'b0;
      pad_din_i = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         checks++;
         if (in_val_o !== (i == 6)) begin
            errors++;
            $display("FAIL post_reset edge %0d: got %b expected %b", i, in_val_o, (i == 6));
         end
      end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_glitch();
      test_irq();
      test_set_clear();
      test_disable();
      test_thresh0();
      test_open_drain();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pad_ctrl.md
PAD_CTRL -- requirements
Module: pad_ctrl

Interface
REQ-001 SHALL have parameter DEB_W, default 8: debounce counter and threshold width in bits.
REQ-002 SHALL have port clk  input  1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-004 SHALL have ports out_val_i (value to drive), out_en_i (output enable), in_en_i (input enable) and od_i (open-drain select), each input 1.
REQ-005 SHALL have port pull_i  input  2: {pu2,pu1} pull select.
REQ-006 SHALL have port irq_mode_i  input  2: 00 off, 01 rising, 10 falling, 11 both edges.
REQ-007 SHALL have port irq_clr_i  input  1: clears pending interrupt.
REQ-008 SHALL have port deb_thresh_i  input  DEB_W: debounce threshold.
REQ-009 SHALL have ports pad_dout_o, pad_eno_o, pad_eni_o, pad_od_o, pad_pu1_o and pad_pu2_o, each output 1, driving the pad cell's DOUT, ENO, ENI, OD, PU1 and PU2 pins.
REQ-010 SHALL have port pad_din_i  input  1: pad cell DIN, asynchronous to clk.
REQ-011 SHALL have port in_val_o  output  1: debounced input level.
REQ-012 SHALL have port irq_o  output  1: pending interrupt, level.

Function
REQ-013 Output path SHALL register all pad_* outputs, 1-cycle latency from the corresponding input.
REQ-014 When od_i=0, the output path SHALL set pad_dout_o<=out_val_i and pad_eno_o<=out_en_i.
REQ-015 When od_i=1, the output path SHALL set pad_dout_o<=0 and pad_eno_o<=out_en_i & ~out_val_i (drive low only, release for 1).
REQ-016 The output path SHALL set pad_od_o<=od_i, pad_eni_o<=in_en_i, pad_pu1_o<=pull_i[0] and pad_pu2_o<=pull_i[1].
REQ-017 Input path SHALL pass pad_din_i through a 2-flop synchronizer (s1, s2), with s1, s2 sampling every cycle regardless of in_en_i.
REQ-018 Debounce SHALL use a DEB_W-bit counter cnt, evaluated each cycle with in_en_i=1.
- s2==in_val_o: cnt<=0.
- s2!=in_val_o and cnt==deb_thresh_i: in_val_o<=s2, cnt<=0.
- s2!=in_val_o and cnt!=deb_thresh_i: cnt<=cnt+1.
REQ-019 Debounce SHALL accept a change after deb_thresh_i+1 consecutive differing s2 samples; a single matching sample SHALL restart the count.
REQ-020 Debounce latency SHALL be in_val_o updating at the (deb_thresh_i+3)th rising edge after a stable pad_din_i change set up before edge 1; threshold 0 gives edge 3.
REQ-021 cnt SHALL NOT exceed deb_thresh_i; if deb_thresh_i is lowered below cnt, cnt SHALL continue incrementing and wrap modulo 2^DEB_W until equal.
REQ-022 When in_en_i=0, cnt SHALL be held at 0, in_val_o SHALL be frozen and no edge SHALL be detected.
REQ-023 Edge detection SHALL assert rise on the edge where in_val_o updates 0->1 and fall on 1->0.
REQ-024 The pending bit SHALL be set on that same edge if (rise & irq_mode_i[0]) | (fall & irq_mode_i[1]).
REQ-025 irq_o SHALL equal the pending register.
REQ-026 irq_clr_i=1 SHALL clear pending on the next edge.
REQ-027 When set and clear coincide, set SHALL win.
REQ-028 Changing irq_mode_i SHALL NOT clear pending.

Reset
REQ-029 rst=1 at an edge SHALL set pad_dout_o=0, pad_eno_o=0, pad_eni_o=0, pad_od_o=0, pad_pu1_o=0, pad_pu2_o=0, s1=s2=0, cnt=0, in_val_o=0, pending=0 (irq_o=0).
REQ-030 Reset SHALL take priority over all other updates, including mid-debounce and a coincident interrupt set.

Verification
REQ-031 Drive: rst 2 cycles, then in_en_i=1, deb_thresh_i=3, pad_din_i 0->1 held -> in_val_o=1 exactly at edge 6 after the change, not before.
REQ-032 Glitch: deb_thresh_i=3, pad_din_i high for 3 cycles then low -> in_val_o stays 0, cnt returns to 0.
REQ-033 IRQ: irq_mode_i=01, rising debounced edge -> irq_o=1 and held; falling edge -> no change; irq_clr_i pulse -> irq_o=0 next edge.
REQ-034 Set+clear: irq_mode_i=11, irq_clr_i=1 on the edge in_val_o toggles -> irq_o=1.
REQ-035 Open-drain: od_i=1, out_en_i=1, out_val_i=0 -> pad_dout_o=0, pad_eno_o=1; with out_val_i=1 -> pad_eno_o=0; all one cycle after input.
REQ-036 Reset mid-op: rst while cnt=2 and irq_o=1 -> all outputs 0 next edge; after release, pad_din_i=1 requires the full thresh+3 edges again.
